// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Definitions shared by the pipeline stage registers.
//   - stage_state_e : handshake FSM states. Each encoding equals the number of
//                     entries held in that state.
//   - DEFAULT_WIDTH : default bits per lane.
//   - occupancy_of  : entry count reported for a given state.
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  // The encoding is chosen so that the state value is also the entry count.
  function automatic logic [1:0] occupancy_of(input stage_state_e s);
    return logic'(s[1]) ? 2'd2 : {1'b0, s[0]};
  endfunction

endpackage : pipeline_pkg

// File: rtl/stage_data_reg.sv
// -----------------------------------------------------------------------------
// stage_data_reg
// Payload register for one pipeline entry. It has a load enable and a
// synchronous clear, and the clear takes priority over the load.
// Ports:
//   clock   in   rising-edge clock
//   reset_n in   asynchronous active-low reset (q -> 0)
//   clear   in   synchronous clear (q -> 0), wins over load
//   load    in   capture d on the next edge
//   d       in   [DW-1:0] next payload
//   q       out  [DW-1:0] held payload
// -----------------------------------------------------------------------------
module stage_data_reg #(
  parameter int DW = 64
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  // NOTE: The payload register is reset even though it is datapath. Stages
  // downstream can observe out_data after reset, so it must read as zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule : stage_data_reg

// File: rtl/hs_stage_reg.sv
// -----------------------------------------------------------------------------
// hs_stage_reg
// A valid/ready pipeline register that carries LANES fields of WIDTH bits
// across one stage boundary. Fields are packed lane-major, with lane 0 in the
// LSBs. The payload is opaque and is never modified.
//   SKID=1 : in_ready comes from a register. A one-entry skid buffer absorbs
//            the beat that arrives while downstream stalls.
//   SKID=0 : a single entry. in_ready = !out_valid | out_ready (combinational).
// flush discards held and incoming beats. reset_n overrides everything.
// Ports:
//   clock     in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   flush     in   synchronous discard of all held and incoming data
//   in_valid  in   upstream beat present
//   in_ready  out  stage accepts a beat this cycle
//   in_data   in   [LANES*WIDTH-1:0] upstream payload
//   out_valid out  downstream beat present
//   out_ready in   downstream accepts this cycle
//   out_data  out  [LANES*WIDTH-1:0] payload to the next stage
//   occupancy out  [1:0] entries held (0, 1, or 2 only when SKID=1)
// -----------------------------------------------------------------------------
module hs_stage_reg
  import pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LANES = 2,
  parameter int SKID  = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [1:0]             occupancy
);

  localparam int DW = LANES * WIDTH;

  stage_state_e   state;
  stage_state_e   state_next;
  logic           main_load;
  logic [DW-1:0]  main_d;
  logic [DW-1:0]  skid_q;
  logic           in_ready_q;

  // NOTE: Every signal written in this block gets a default value first. A
  // path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_next = state;
    main_load  = 1'b0;
    main_d     = in_data;
    unique case (state)
      ST_EMPTY: begin
        if (in_valid) begin
          state_next = ST_FULL;
          main_load  = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_ready && in_valid) begin
          main_load = 1'b1;                 // replace the beat leaving now
        end else if (out_ready) begin
          state_next = ST_EMPTY;            // out_data keeps its last value
        end else if (in_valid && SKID != 0) begin
          state_next = ST_SKID;             // the beat goes to the skid entry
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          state_next = ST_FULL;
          main_load  = 1'b1;
          main_d     = skid_q;              // older beat moves up, FIFO order
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    // flush has priority over every transfer. The data registers clear
    // themselves through their clear input.
    if (flush) begin
      state_next = ST_EMPTY;
    end
  end

  // NOTE: Sequential state uses non-blocking assignments. Other always_ff
  // blocks then read the pre-edge values, as the hardware does.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      out_valid  <= 1'b0;
      occupancy  <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      out_valid  <= (state_next != ST_EMPTY);
      occupancy  <= occupancy_of(state_next);
      in_ready_q <= (state_next != ST_SKID);
    end
  end

  // With a skid entry, in_ready is the registered flag and has no path from
  // out_ready. Without one, the single entry can be refilled in the same
  // cycle it drains.
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);

  stage_data_reg #(.DW(DW)) u_main (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (flush),
    .load    (main_load),
    .d       (main_d),
    .q       (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      // Capture only while downstream is stalled and main is occupied.
      logic skid_load;
      assign skid_load = (state == ST_FULL) && in_valid && !out_ready;

      stage_data_reg #(.DW(DW)) u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (flush),
        .load    (skid_load),
        .d       (in_data),
        .q       (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

endmodule : hs_stage_reg

// File: tb/tb_hs_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_hs_stage_reg
// Drives the SKID=1 and SKID=0 builds in lockstep from shared inputs.
// Directed scenario tasks are followed by a randomized run, which is checked
// against a bounded FIFO model of each build.
// -----------------------------------------------------------------------------
module tb_hs_stage_reg;

  localparam int W  = 32;
  localparam int L  = 2;
  localparam int DW = W * L;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_data1, out_data0;
  logic [1:0]    occ1, occ0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  hs_stage_reg #(.WIDTH(W), .LANES(L), .SKID(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1)
  );

  hs_stage_reg #(.WIDTH(W), .LANES(L), .SKID(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hDEADBEEF_00000004;
    out_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid1 got=%b exp=0", out_valid1); end
    n_cmp++; if (out_data1 !== '0) begin n_err++; $display("FAIL reset_out_data1 got=%h exp=0", out_data1); end
    n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready1 got=%b exp=1", in_ready1); end
    n_cmp++; if (occ1 !== 2'd0) begin n_err++; $display("FAIL reset_occ1 got=%0d exp=0", occ1); end
    n_cmp++; if (out_valid0 !== 1'b0 || out_data0 !== '0 || occ0 !== 2'd0)
      begin n_err++; $display("FAIL reset_dut0 got v=%b d=%h o=%0d exp 0/0/0", out_valid0, out_data0, occ0); end
    reset_n = 1'b1;
    tick();
    n_cmp++; if (out_valid1 !== 1'b1 || out_data1 !== 64'hDEADBEEF_00000004)
      begin n_err++; $display("FAIL reset_release1 got v=%b d=%h exp 1/deadbeef00000004", out_valid1, out_data1); end
    n_cmp++; if (out_valid0 !== 1'b1 || out_data0 !== 64'hDEADBEEF_00000004)
      begin n_err++; $display("FAIL reset_release0 got v=%b d=%h exp 1/deadbeef00000004", out_valid0, out_data0); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid1 !== 1'b0 || out_data1 !== 64'hDEADBEEF_00000004)
      begin n_err++; $display("FAIL drain_holds_data got v=%b d=%h exp 0/deadbeef00000004", out_valid1, out_data1); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_streaming();
    logic [DW-1:0] exp_d;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      exp_d    = {32'hC0DE0000 | 32'(i), 32'(i)};
      in_data  = exp_d;
      in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1)
        begin n_err++; $display("FAIL stream_in_ready beat=%0d got=%b/%b exp=1/1", i, in_ready1, in_ready0); end
      tick();
      n_cmp++; if (out_valid1 !== 1'b1 || out_data1 !== exp_d)
        begin n_err++; $display("FAIL stream_out1 beat=%0d got v=%b d=%h exp 1/%h", i, out_valid1, out_data1, exp_d); end
      n_cmp++; if (out_valid0 !== 1'b1 || out_data0 !== exp_d)
        begin n_err++; $display("FAIL stream_out0 beat=%0d got v=%b d=%h exp 1/%h", i, out_valid0, out_data0, exp_d); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall_skid();
    logic [DW-1:0] a, b;
    a = 64'hAAAA0001_0000000A;
    b = 64'hBBBB0002_0000000B;
    in_valid = 1'b1; in_data = a; out_ready = 1'b0;
    tick();
    in_data = b;
    tick();
    n_cmp++; if (occ1 !== 2'd2) begin n_err++; $display("FAIL skid_occ got=%0d exp=2", occ1); end
    n_cmp++; if (in_ready1 !== 1'b0) begin n_err++; $display("FAIL skid_in_ready got=%b exp=0", in_ready1); end
    n_cmp++; if (out_data1 !== a) begin n_err++; $display("FAIL skid_out_a got=%h exp=%h", out_data1, a); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid1 !== 1'b1 || out_data1 !== a)
      begin n_err++; $display("FAIL skid_stable got v=%b d=%h exp 1/%h", out_valid1, out_data1, a); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready1 !== 1'b0) begin n_err++; $display("FAIL skid_no_comb_ready got=%b exp=0", in_ready1); end
    tick();
    n_cmp++; if (out_valid1 !== 1'b1 || out_data1 !== b || occ1 !== 2'd1 || in_ready1 !== 1'b1)
      begin n_err++; $display("FAIL skid_then_b got v=%b d=%h o=%0d r=%b exp 1/%h/1/1", out_valid1, out_data1, occ1, in_ready1, b); end
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL noskid_b_dropped got v=%b exp=0", out_valid0); end
    tick();
    n_cmp++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0)
      begin n_err++; $display("FAIL skid_drained got v=%b o=%0d exp 0/0", out_valid1, occ1); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    in_valid = 1'b1; in_data = 64'h11110000_00000001; out_ready = 1'b0;
    tick();
    in_data = 64'h22220000_00000002;
    tick();
    n_cmp++; if (occ1 !== 2'd2) begin n_err++; $display("FAIL flush_setup_occ got=%0d exp=2", occ1); end
    in_data = 64'hCCCC0000_0000000C;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (out_valid1 !== 1'b0 || out_data1 !== '0 || occ1 !== 2'd0 || in_ready1 !== 1'b1)
      begin n_err++; $display("FAIL flush1 got v=%b d=%h o=%0d r=%b exp 0/0/0/1", out_valid1, out_data1, occ1, in_ready1); end
    n_cmp++; if (out_valid0 !== 1'b0 || out_data0 !== '0 || occ0 !== 2'd0)
      begin n_err++; $display("FAIL flush0 got v=%b d=%h o=%0d exp 0/0/0", out_valid0, out_data0, occ0); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid1 !== 1'b0 || out_data1 !== '0)
      begin n_err++; $display("FAIL flush_c_gone got v=%b d=%h exp 0/0", out_valid1, out_data1); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_skid0();
    logic [DW-1:0] d_beat, e_beat;
    d_beat = 64'hD0D0D0D0_0000000D;
    e_beat = 64'hE0E0E0E0_0000000E;
    in_valid = 1'b1; in_data = d_beat; out_ready = 1'b0;
    tick();
    in_data = e_beat;
    #1;
    n_cmp++; if (in_ready0 !== 1'b0) begin n_err++; $display("FAIL noskid_stall_ready got=%b exp=0", in_ready0); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL noskid_comb_ready got=%b exp=1", in_ready0); end
    tick();
    n_cmp++; if (out_valid0 !== 1'b1 || out_data0 !== e_beat)
      begin n_err++; $display("FAIL noskid_replace got v=%b d=%h exp 1/%h", out_valid0, out_data0, e_beat); end
    in_valid = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 64'h33330000_00000003; out_ready = 1'b0;
    tick();
    in_data = 64'h44440000_00000004;
    tick();
    n_cmp++; if (occ1 !== 2'd2) begin n_err++; $display("FAIL areset_setup_occ got=%0d exp=2", occ1); end
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid1 !== 1'b0 || out_data1 !== '0 || occ1 !== 2'd0 || in_ready1 !== 1'b1)
      begin n_err++; $display("FAIL areset1 got v=%b d=%h o=%0d r=%b exp 0/0/0/1", out_valid1, out_data1, occ1, in_ready1); end
    n_cmp++; if (out_valid0 !== 1'b0 || out_data0 !== '0 || occ0 !== 2'd0)
      begin n_err++; $display("FAIL areset0 got v=%b d=%h o=%0d exp 0/0/0", out_valid0, out_data0, occ0); end
    reset_n = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Each build behaves as a bounded FIFO: capacity 2 with registered ready for
  // SKID=1, and capacity 1 that can refill while draining for SKID=0. When a
  // FIFO is empty, out_data shows the last beat popped (0 after a flush).
  task automatic test_random();
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] last1, last0, exp_d1, exp_d0;
    logic          exp_r1, exp_r0;
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    flush = 1'b0;
    last1 = '0;
    last0 = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = {$urandom, $urandom};
      #1;
      exp_r1 = (q1.size() < 2);
      exp_r0 = (q0.size() == 0) || out_ready;
      exp_d1 = (q1.size() > 0) ? q1[0] : last1;
      exp_d0 = (q0.size() > 0) ? q0[0] : last0;
      n_cmp++; if (in_ready1 !== exp_r1 || out_valid1 !== (q1.size() > 0) || occ1 !== 2'(q1.size()))
        begin n_err++; $display("FAIL rand1_ctl cyc=%0d got r=%b v=%b o=%0d exp %b/%b/%0d", cyc, in_ready1, out_valid1, occ1, exp_r1, q1.size() > 0, q1.size()); end
      n_cmp++; if (out_data1 !== exp_d1)
        begin n_err++; $display("FAIL rand1_data cyc=%0d got=%h exp=%h", cyc, out_data1, exp_d1); end
      n_cmp++; if (in_ready0 !== exp_r0 || out_valid0 !== (q0.size() > 0) || occ0 !== 2'(q0.size()))
        begin n_err++; $display("FAIL rand0_ctl cyc=%0d got r=%b v=%b o=%0d exp %b/%b/%0d", cyc, in_ready0, out_valid0, occ0, exp_r0, q0.size() > 0, q0.size()); end
      n_cmp++; if (out_data0 !== exp_d0)
        begin n_err++; $display("FAIL rand0_data cyc=%0d got=%h exp=%h", cyc, out_data0, exp_d0); end
      @(posedge clock);
      if (flush) begin
        q1.delete(); q0.delete();
        last1 = '0; last0 = '0;
      end else begin
        if (q1.size() > 0 && out_ready) last1 = q1.pop_front();
        if (in_valid && exp_r1) q1.push_back(in_data);
        if (q0.size() > 0 && out_ready) last0 = q0.pop_front();
        if (in_valid && exp_r0) q0.push_back(in_data);
      end
      #1;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_skid0();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_hs_stage_reg
